spi_xfer_ctrl: RTL

//  Transfer sequencer for the SPI peripheral. Pops words from the TX FIFO, drives chip-select,

---
 rtl/spi_xfer_if.sv | 27 ++
 rtl/spi_xfer_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/spi_xfer_if.sv
// Word-FIFO handshake and SPI pin bundle for the transfer sequencer.
// The sequencer is the bus master on both the FIFO strobes and the SPI pins.
interface spi_xfer_if #(
  parameter int MAXW = 32,
  parameter int NCS  = 4
);
  logic            tx_empty;
  logic [MAXW-1:0] tx_data;
  logic            tx_pop;
  logic            rx_full;
  logic [MAXW-1:0] rx_data;
  logic            rx_push;
  logic            spi_clk;
  logic            spi_tx;
  logic            spi_rx;
  logic [NCS-1:0]  spi_cs_n;

  modport master (
    input  tx_empty, tx_data, rx_full, spi_rx,
    output tx_pop, rx_data, rx_push, spi_clk, spi_tx, spi_cs_n
  );

  modport slave (
    output tx_empty, tx_data, rx_full, spi_rx,
    input  tx_pop, rx_data, rx_push, spi_clk, spi_tx, spi_cs_n
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: pops a TX word, shifts it out MSB first in the
// selected SPI mode while sampling MISO, then pushes the received word.
// All SPI timing advances on half_tick (one pulse per SCLK half-period).
module spi_xfer_ctrl #(
  parameter int MAXW = 32,
  parameter int NCS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      half_tick,
  input  logic [$clog2(MAXW)-1:0]   word_size,
  input  logic [NCS-1:0]            cs_auto,
  input  logic [NCS-1:0]            cs_enable,
  input  logic [$clog2(NCS)-1:0]    cs_select,
  input  logic [2*NCS-1:0]          mode_flat,
  spi_xfer_if.master                bus,
  output logic                      busy
);

  localparam int WSW  = $clog2(MAXW);
  localparam int SELW = $clog2(NCS);
  localparam int CW   = WSW + 2;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [MAXW-1:0] shreg, rxreg, aligned;
  logic [CW-1:0]   edge_cnt, last_edge;
  logic [WSW:0]    nbits;
  logic [SELW-1:0] target, target_nxt;
  logic            cpol, cpha;
  logic [1:0]      sel_mode;
  logic            last, lead;
  logic [NCS-1:0]  cs_n_nxt;

  // {CPOL,CPHA} of the currently selected device (live, used while idle)
  assign sel_mode  = mode_flat[{cs_select, 1'b0} +: 2];
  // Left-justify the word so the MSB always sits at shreg[MAXW-1]
  assign aligned   = bus.tx_data << (WSW'(MAXW - 1) - word_size);
  assign last_edge = {nbits, 1'b0} - CW'(1);
  assign last      = (edge_cnt == last_edge);
  assign lead      = ~edge_cnt[0];
  assign busy      = (state != IDLE);
  assign bus.rx_data = rxreg;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and single-cycle FIFO strobes
  always_comb begin
    state_nxt   = state;
    bus.tx_pop  = 1'b0;
    bus.rx_push = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (!bus.tx_empty && !bus.rx_full && half_tick) begin
          bus.tx_pop = 1'b1;
          state_nxt  = SETUP;
        end
        SETUP: if (half_tick) state_nxt = SHIFT;
        SHIFT: if (half_tick && last) state_nxt = HOLD;
        HOLD: if (half_tick) begin
          bus.rx_push = 1'b1;
          state_nxt   = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign target_nxt = bus.tx_pop ? cs_select : target;

  // Per-line chip-select: manual lines follow cs_enable, auto lines assert
  // only for the latched target while a word is in flight. Computed from the
  // next state so CS moves on the same edge as the state change.
  for (genvar i = 0; i < NCS; i++) begin : g_cs
    assign cs_n_nxt[i] = cs_auto[i] ? ~((state_nxt != IDLE) && (target_nxt == SELW'(i)))
                                    : ~cs_enable[i];
  end

  // Datapath: word latch, SCLK generation, MOSI drive, MISO sampling, CS
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      rxreg        <= '0;
      edge_cnt     <= '0;
      nbits        <= '0;
      target       <= '0;
      cpol         <= 1'b0;
      cpha         <= 1'b0;
      bus.spi_clk  <= sel_mode[1];
      bus.spi_tx   <= 1'b0;
      bus.spi_cs_n <= ~(cs_enable & ~cs_auto);
    end else begin
      bus.spi_cs_n <= cs_n_nxt;
      if (!enable) begin
        // Abort: word is dropped, SCLK parks at the selected idle level
        rxreg       <= '0;
        edge_cnt    <= '0;
        bus.spi_clk <= sel_mode[1];
        bus.spi_tx  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bus.spi_clk <= sel_mode[1];
            bus.spi_tx  <= 1'b0;
            if (bus.tx_pop) begin
              shreg    <= aligned;
              rxreg    <= '0;
              nbits    <= {1'b0, word_size} + 1'b1;
              target   <= cs_select;
              cpol     <= sel_mode[1];
              cpha     <= sel_mode[0];
              edge_cnt <= '0;
              // CPHA=0 presents the MSB before the first (sampling) edge
              if (!sel_mode[0]) bus.spi_tx <= aligned[MAXW-1];
            end
          end
          SETUP: if (half_tick) edge_cnt <= '0;
          SHIFT: if (half_tick) begin
            bus.spi_clk <= ~bus.spi_clk;
            edge_cnt    <= edge_cnt + 1'b1;
            // Sample on leading edges for CPHA=0, trailing edges for CPHA=1
            if (lead ^ cpha) begin
              rxreg <= {rxreg[MAXW-2:0], bus.spi_rx};
            end else begin
              bus.spi_tx <= cpha ? shreg[MAXW-1] : shreg[MAXW-2];
              shreg      <= shreg << 1;
            end
          end
          HOLD: if (half_tick) begin
            bus.spi_tx  <= 1'b0;
            bus.spi_clk <= cpol;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
